key_filter_multi: RTL and testbench
===================================

Name: key_filter_multi

Overview:
Parametrised multi-channel push-button debouncer, the successor to the single-key 20 ms filter. Each channel synchronises an active-low raw key input and debounces both press and release. It provides a debounced level plus one-cycle press, release and long-press pulses. It sits between board key pins and control logic such as LED/mode FSMs and counters.

Parameters:
KEY_NUM, 4, number of independent key channels (1..32).
CNT_MAX_20MS, 999_999, stable-sample window in sys_clk cycles (20 ms at 50 MHz); benches override to 24.
CNT_MAX_LONG, 49_999_999, held-pressed time in cycles before the long-press pulse (1 s at 50 MHz); benches override to 100.
Counter widths are local: $clog2(CNT_MAX_20MS+1) and $clog2(CNT_MAX_LONG+1).

Ports:
sys_clk  in  1  system clock.
sys_rst_n  in  1  asynchronous, active-low reset.
key_in  in  KEY_NUM  raw key pins, asynchronous; 0 = pressed, 1 = released.
key_state  out  KEY_NUM  debounced level; 1 = pressed.
key_press  out  KEY_NUM  one-cycle pulse on each debounced press.
key_release  out  KEY_NUM  one-cycle pulse on each debounced release.
key_long  out  KEY_NUM  one-cycle pulse once per press after CNT_MAX_LONG cycles held.

Behaviour:
- Reset value of all outputs is 0. Synchroniser flops reset to 1 (released). All counters reset to 0.
- Reset is honoured mid-operation: every channel returns to released, with no pulses on the cycle reset deasserts.
- Channels are fully independent. Identical logic is generated per bit with a generate loop.
- Synchroniser: 2 flops per channel. key_sync = inverted second flop, so 1 = pressed.
- Debounce counter deb_cnt, per channel:
  - key_sync == key_state: deb_cnt <= 0.
  - key_sync != key_state and deb_cnt < CNT_MAX_20MS-1: deb_cnt <= deb_cnt+1.
  - key_sync != key_state and deb_cnt == CNT_MAX_20MS-1: deb_cnt <= 0, key_state <= key_sync, and the matching key_press or key_release pulses high on that same edge for exactly 1 cycle.
- A mismatch must therefore persist CNT_MAX_20MS consecutive cycles before it is accepted. Any single-cycle return to the debounced level restarts the window. Glitches shorter than the window produce no output change.
- Latency: a clean raw edge to key_state change and pulse is CNT_MAX_20MS+2 sys_clk edges (2 synchroniser cycles plus the window).
- Long counter long_cnt, per channel:
  - key_state == 0: long_cnt <= 0.
  - key_state == 1 and long_cnt < CNT_MAX_LONG: long_cnt <= long_cnt+1. It saturates at CNT_MAX_LONG.
  - key_long pulses for 1 cycle on the edge where long_cnt goes CNT_MAX_LONG-1 -> CNT_MAX_LONG. This gives exactly one pulse per press, with no repeat while held.
  - Release clears long_cnt. A release always emits key_release, whether or not key_long fired.
- key_press and key_release are never high together on one channel. Simultaneous events on different channels are all reported in the same cycle.
- Outputs are registered; there are no combinational paths from key_in.

Test Plan:
1. Reset held, key_in toggling -> all outputs 0. Release reset with key_in=all 1 -> no pulses for 200 cycles.
2. CNT_MAX_20MS=24, clean press on key_in[0] -> key_press[0] high exactly 26 cycles after the first sampling edge, for 1 cycle; key_state[0]=1; other channels stay 0.
3. Bounce: key_in[1] low for 10 cycles, high for 1 cycle, then low steady -> key_press[1] arrives 26 cycles after the final low edge. No pulse occurs from the 10-cycle burst.
4. CNT_MAX_LONG=100, hold key 2 for 300 cycles -> key_press[2] once, then key_long[2] once exactly 100 cycles later, no repeat. On release, key_release[2] once after 26 cycles and key_state[2]=0.
5. Press keys 0 and 3 on the same edge -> key_press=4'b1001 in a single cycle. Release key 0 only -> key_release=4'b0001.
6. Assert sys_rst_n mid-window (deb_cnt=15) and mid-long-hold -> outputs 0 immediately. After deassert with the key still held, a fresh 26-cycle press is detected.

Source files
------------

// File: rtl/key_filter_multi.sv
// key_filter_multi: multi-channel push-button debouncer.
// Each channel synchronises an active-low raw key, debounces press and
// release over a stable-sample window, and reports a debounced level plus
// one-cycle press, release and long-press pulses. All outputs are registered.
module key_filter_multi #(
  parameter int KEY_NUM      = 4,
  parameter int CNT_MAX_20MS = 999_999,
  parameter int CNT_MAX_LONG = 49_999_999
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic [KEY_NUM-1:0] key_in,
  output logic [KEY_NUM-1:0] key_state,
  output logic [KEY_NUM-1:0] key_press,
  output logic [KEY_NUM-1:0] key_release,
  output logic [KEY_NUM-1:0] key_long
);

  localparam int DEB_W  = $clog2(CNT_MAX_20MS + 1);
  localparam int LONG_W = $clog2(CNT_MAX_LONG + 1);

  // Last count of the debounce window; reaching it with a mismatch accepts the new level.
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(CNT_MAX_20MS - 1);
  localparam logic [DEB_W-1:0]  DEB_ONE   = DEB_W'(1);
  // Saturation value of the hold counter and the count just before it.
  localparam logic [LONG_W-1:0] LONG_MAX  = LONG_W'(CNT_MAX_LONG);
  localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(CNT_MAX_LONG - 1);
  localparam logic [LONG_W-1:0] LONG_ONE  = LONG_W'(1);

  for (genvar g = 0; g < KEY_NUM; g++) begin : g_chan
    logic              sync_q1;
    logic              sync_q2;
    logic              key_sync;
    logic [DEB_W-1:0]  deb_cnt;
    logic              state_q;
    logic              press_q;
    logic              release_q;
    logic [LONG_W-1:0] long_cnt;
    logic              long_q;

    // Two-flop synchroniser; flops idle at 1 so a reset channel reads as released.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        sync_q1 <= 1'b1;
        sync_q2 <= 1'b1;
      end else begin
        sync_q1 <= key_in[g];
        sync_q2 <= sync_q1;
      end
    end

    assign key_sync = ~sync_q2;

    // Debounce: a mismatch must survive the whole window before the level flips.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        deb_cnt   <= '0;
        state_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        press_q   <= 1'b0;
        release_q <= 1'b0;
        if (key_sync == state_q) begin
          deb_cnt <= '0;
        end else if (deb_cnt == DEB_LAST) begin
          deb_cnt   <= '0;
          state_q   <= key_sync;
          press_q   <= key_sync;
          release_q <= ~key_sync;
        end else begin
          deb_cnt <= deb_cnt + DEB_ONE;
        end
      end
    end

    // Hold timer: counts while pressed, saturates, and fires once on reaching the limit.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        long_cnt <= '0;
        long_q   <= 1'b0;
      end else begin
        long_q <= 1'b0;
        if (!state_q) begin
          long_cnt <= '0;
        end else if (long_cnt < LONG_MAX) begin
          long_cnt <= long_cnt + LONG_ONE;
          long_q   <= (long_cnt == LONG_LAST);
        end
      end
    end

    assign key_state[g]   = state_q;
    assign key_press[g]   = press_q;
    assign key_release[g] = release_q;
    assign key_long[g]    = long_q;
  end

endmodule

// File: tb/tb_key_filter_multi.sv
// tb_key_filter_multi: directed and randomised bench for key_filter_multi.
// A behavioural model tracks each channel as "the last WINDOW synchronised
// samples all disagree with the debounced level" and "cycles held since press".
module tb_key_filter_multi;

  localparam int KEY_NUM = 4;
  localparam int WINDOW  = 24;
  localparam int LONG_T  = 100;
  localparam int LAT     = WINDOW + 2;

  logic               sys_clk   = 1'b0;
  logic               sys_rst_n = 1'b0;
  logic [KEY_NUM-1:0] key_in    = '1;
  logic [KEY_NUM-1:0] key_state;
  logic [KEY_NUM-1:0] key_press;
  logic [KEY_NUM-1:0] key_release;
  logic [KEY_NUM-1:0] key_long;

  int n_vectors     = 0;
  int n_miscompares = 0;

  always #5 sys_clk = ~sys_clk;

  key_filter_multi #(
    .KEY_NUM      (KEY_NUM),
    .CNT_MAX_20MS (WINDOW),
    .CNT_MAX_LONG (LONG_T)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .key_in      (key_in),
    .key_state   (key_state),
    .key_press   (key_press),
    .key_release (key_release),
    .key_long    (key_long)
  );

  // Reference model state
  logic [KEY_NUM-1:0] raw_q[$];
  logic [WINDOW-1:0]  samp_hist [KEY_NUM];
  int                 held [KEY_NUM];
  logic [KEY_NUM-1:0] exp_state, exp_press, exp_release, exp_long;
  logic [KEY_NUM-1:0] synced;

  // Model: raw pins reach the filter two edges late; a level is accepted once
  // the last WINDOW samples all oppose it; long fires when held hits LONG_T.
  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      raw_q.delete();
      raw_q.push_back({KEY_NUM{1'b1}});
      raw_q.push_back({KEY_NUM{1'b1}});
      exp_state   = '0;
      exp_press   = '0;
      exp_release = '0;
      exp_long    = '0;
      for (int ch = 0; ch < KEY_NUM; ch++) begin
        samp_hist[ch] = '0;
        held[ch]      = 0;
      end
    end else begin
      synced = ~raw_q.pop_front();
      raw_q.push_back(key_in);
      exp_press   = '0;
      exp_release = '0;
      exp_long    = '0;
      for (int ch = 0; ch < KEY_NUM; ch++) begin
        if (exp_state[ch]) begin
          held[ch]++;
          if (held[ch] == LONG_T) exp_long[ch] = 1'b1;
        end else begin
          held[ch] = 0;
        end
        samp_hist[ch] = {samp_hist[ch][WINDOW-2:0], synced[ch]};
        if (samp_hist[ch] == {WINDOW{~exp_state[ch]}}) begin
          exp_state[ch] = ~exp_state[ch];
          if (exp_state[ch]) exp_press[ch] = 1'b1;
          else               exp_release[ch] = 1'b1;
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_vectors++;
    if (observed !== expected) begin
      n_miscompares++;
      $display("[TB] FAIL %s: observed %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic compareModel();
    checkOutput("key_state",   32'(key_state),   32'(exp_state));
    checkOutput("key_press",   32'(key_press),   32'(exp_press));
    checkOutput("key_release", 32'(key_release), 32'(exp_release));
    checkOutput("key_long",    32'(key_long),    32'(exp_long));
  endtask

  // Drive keys for a number of cycles, comparing against the model each cycle.
  task automatic applyStimulus(input logic [KEY_NUM-1:0] keys, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      key_in = keys;
      @(negedge sys_clk);
      compareModel();
    end
  endtask

  function automatic logic [KEY_NUM-1:0] pulseVec(input int kind);
    case (kind)
      0:       return key_press;
      1:       return key_release;
      default: return key_long;
    endcase
  endfunction

  // Cycles from driving keys until the selected pulse appears on a channel; -1 if never.
  task automatic measureLatency(input logic [KEY_NUM-1:0] keys, input int ch,
                                input int kind, input int budget, output int lat);
    logic [KEY_NUM-1:0] pv;
    lat = -1;
    for (int i = 1; i <= budget; i++) begin
      applyStimulus(keys, 1);
      pv = pulseVec(kind);
      if (pv[ch]) begin
        lat = i;
        break;
      end
    end
  endtask

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    int rem [KEY_NUM];
    logic [KEY_NUM-1:0] lvl;

    // Reset held with pins toggling, then released idle.
    for (int i = 0; i < 10; i++) applyStimulus(KEY_NUM'($urandom), 1);
    checkOutput("rst_state", 32'(key_state), 32'h0);
    checkOutput("rst_press", 32'(key_press), 32'h0);
    sys_rst_n = 1'b1;
    applyStimulus('1, 200);

    // Clean press on key 0.
    measureLatency(4'b1110, 0, 0, 60, lat);
    checkOutput("t2_press_lat", 32'(lat), 32'(LAT));
    checkOutput("t2_state", 32'(key_state), 32'h1);
    applyStimulus(4'b1110, 10);
    applyStimulus('1, 40);

    // Bounce on key 1: 10 low, 1 high, then steady low.
    applyStimulus(4'b1101, 10);
    applyStimulus(4'b1111, 1);
    measureLatency(4'b1101, 1, 0, 60, lat);
    checkOutput("t3_press_lat", 32'(lat), 32'(LAT));
    applyStimulus('1, 40);

    // Long hold on key 2.
    measureLatency(4'b1011, 2, 0, 60, lat);
    checkOutput("t4_press_lat", 32'(lat), 32'(LAT));
    measureLatency(4'b1011, 2, 2, 200, lat);
    checkOutput("t4_long_lat", 32'(lat), 32'(LONG_T));
    applyStimulus(4'b1011, 170);
    measureLatency(4'b1111, 2, 1, 60, lat);
    checkOutput("t4_release_lat", 32'(lat), 32'(LAT));
    checkOutput("t4_state", 32'(key_state), 32'h0);
    applyStimulus('1, 10);

    // Simultaneous press of keys 0 and 3, then release of key 0 alone.
    applyStimulus(4'b0110, LAT);
    checkOutput("t5_press", 32'(key_press), 32'h9);
    applyStimulus(4'b0110, 30);
    applyStimulus(4'b0111, LAT);
    checkOutput("t5_release", 32'(key_release), 32'h1);
    applyStimulus('1, 40);

    // Reset mid-long-hold (key 2) and mid-window (key 1), keys still held after.
    applyStimulus(4'b1011, 60);
    applyStimulus(4'b1001, 17);
    sys_rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_state", 32'(key_state), 32'h0);
    checkOutput("t6_rst_long",  32'(key_long),  32'h0);
    applyStimulus(4'b1001, 3);
    sys_rst_n = 1'b1;
    measureLatency(4'b1001, 1, 0, 60, lat);
    checkOutput("t6_press_lat", 32'(lat), 32'(LAT));
    checkOutput("t6_press", 32'(key_press), 32'h6);
    applyStimulus('1, 40);

    // Randomised run: mix of glitches, short presses, long holds, rare resets.
    lvl = '1;
    for (int ch = 0; ch < KEY_NUM; ch++) rem[ch] = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (!sys_rst_n) sys_rst_n = 1'b1;
      else if ($urandom_range(0, 799) == 0) sys_rst_n = 1'b0;
      for (int ch = 0; ch < KEY_NUM; ch++) begin
        if (rem[ch] == 0) begin
          lvl[ch] = ~lvl[ch];
          case ($urandom_range(0, 3))
            0:       rem[ch] = $urandom_range(1, 5);
            1:       rem[ch] = $urandom_range(10, 30);
            2:       rem[ch] = $urandom_range(30, 60);
            default: rem[ch] = $urandom_range(100, 180);
          endcase
        end
        rem[ch]--;
      end
      applyStimulus(lvl, 1);
    end
    sys_rst_n = 1'b1;
    applyStimulus('1, 60);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
